// File: rtl/mpu_mem_arbiter.sv
// mpu_mem_arbiter
//   Shares the single MPU program/data memory between the host loader and the
//   MPU core. Round-robin arbitration, one access per 3-cycle transaction
//   (IDLE -> ACCESS -> DONE), byte-address range checking with an error
//   acknowledge, and a host exclusive mode that locks the MPU out.
//
// Ports
//   sys_clk, sys_rst         : clock, synchronous active-high reset
//   h_req/h_we/h_addr/h_wdata: host request, direction, byte address, data
//   h_excl                   : host exclusive mode (MPU never granted)
//   h_ack/h_err/h_rdata      : host completion pulse, range error, read data
//   m_req/m_we/m_addr/m_wdata: MPU request, direction, byte address, data
//   m_ack/m_err/m_rdata      : MPU completion pulse, range error, read data
//   r_addr/r_data            : memory read port (r_data combinational)
//   we/w_addr/w_data         : memory write port (w_data[32] always 0)
module mpu_mem_arbiter #(
  parameter logic [15:0] ADDR_MAX = 16'd128,
  parameter int          RD_BYTES = 6,
  parameter int          WR_BYTES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [15:0] h_addr,
  input  logic [31:0] h_wdata,
  input  logic        h_excl,
  output logic        h_ack,
  output logic        h_err,
  output logic [47:0] h_rdata,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [15:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic        m_err,
  output logic [47:0] m_rdata,
  output logic [15:0] r_addr,
  input  logic [47:0] r_data,
  output logic        we,
  output logic [15:0] w_addr,
  output logic [32:0] w_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Range checks run at 17 bits so an address near 16'hFFFF cannot wrap into range.
  localparam logic [16:0] RD_SPAN = 17'(RD_BYTES - 1);
  localparam logic [16:0] WR_SPAN = 17'(WR_BYTES - 1);
  localparam logic [16:0] LIMIT   = {1'b0, ADDR_MAX};

  state_t      r_state;
  logic        r_last_m;   // 1: last grant went to the MPU
  logic        r_gnt_m;    // owner of the transaction in flight
  logic        r_we_cap;   // captured direction
  logic        r_err;      // captured range-error flag

  logic        w_cand_m;
  logic        w_gnt_h;
  logic        w_gnt_m;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [16:0] w_end;
  logic        w_legal;

  // Arbitration, request mux and range check for the request about to be captured.
  always_comb begin
    w_cand_m    = m_req & ~h_excl;
    // On a tie the requester that did not win last time gets the slot.
    w_gnt_m     = w_cand_m & (~h_req | ~r_last_m);
    w_gnt_h     = h_req & ~w_gnt_m;
    w_sel_we    = 1'b0;
    w_sel_addr  = 16'h0000;
    w_sel_wdata = 32'h0000_0000;
    w_end       = 17'h0_0000;
    w_legal     = 1'b0;
    if (w_gnt_m) begin
      w_sel_we    = m_we;
      w_sel_addr  = m_addr;
      w_sel_wdata = m_wdata;
    end else begin
      w_sel_we    = h_we;
      w_sel_addr  = h_addr;
      w_sel_wdata = h_wdata;
    end
    if (w_sel_we) begin
      w_end = {1'b0, w_sel_addr} + WR_SPAN;
    end else begin
      w_end = {1'b0, w_sel_addr} + RD_SPAN;
    end
    w_legal = (w_end <= LIMIT);
  end

  // Transaction FSM with registered memory-port and requester outputs.
  // The memory-port registers double as the capture registers: they are
  // loaded at grant so they present the access during exactly the ACCESS cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_last_m <= 1'b1;
      r_gnt_m  <= 1'b0;
      r_we_cap <= 1'b0;
      r_err    <= 1'b0;
      h_ack    <= 1'b0;
      h_err    <= 1'b0;
      h_rdata  <= 48'h0000_0000_0000;
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= 48'h0000_0000_0000;
      r_addr   <= 16'h0000;
      we       <= 1'b0;
      w_addr   <= 16'h0000;
      w_data   <= 33'h0_0000_0000;
    end else begin
      h_ack <= 1'b0;
      h_err <= 1'b0;
      m_ack <= 1'b0;
      m_err <= 1'b0;
      we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_h || w_gnt_m) begin
            r_gnt_m  <= w_gnt_m;
            r_last_m <= w_gnt_m;
            r_we_cap <= w_sel_we;
            r_err    <= ~w_legal;
            // Illegal accesses never reach the memory port.
            if (w_legal && w_sel_we) begin
              we     <= 1'b1;
              w_addr <= w_sel_addr;
              w_data <= {1'b0, w_sel_wdata};
            end
            if (w_legal && !w_sel_we) begin
              r_addr <= w_sel_addr;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we_cap && !r_err) begin
            if (r_gnt_m) begin
              m_rdata <= r_data;
            end else begin
              h_rdata <= r_data;
            end
          end
          // Ack and error become visible during DONE.
          if (r_gnt_m) begin
            m_ack <= 1'b1;
            m_err <= r_err;
          end else begin
            h_ack <= 1'b1;
            h_err <= r_err;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_mem_arbiter.sv
// tb_mpu_mem_arbiter
//   Directed bench for mpu_mem_arbiter with a 256-byte little-endian memory
//   model behind the arbiter's memory ports.
module tb_mpu_mem_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic        h_req, h_we, h_excl;
  logic [15:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_ack, h_err;
  logic [47:0] h_rdata;
  logic        m_req, m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack, m_err;
  logic [47:0] m_rdata;
  logic [15:0] r_addr;
  logic [47:0] r_data;
  logic        we;
  logic [15:0] w_addr;
  logic [32:0] w_data;

  logic [7:0]  mem [0:255];
  logic        mem_clr;
  logic [7:0]  ra;

  int n_cmp = 0;
  int n_mis = 0;
  int n_h_ack = 0;
  int n_m_ack = 0;
  int n_dual = 0;

  mpu_mem_arbiter dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .h_req   (h_req),
    .h_we    (h_we),
    .h_addr  (h_addr),
    .h_wdata (h_wdata),
    .h_excl  (h_excl),
    .h_ack   (h_ack),
    .h_err   (h_err),
    .h_rdata (h_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .we      (we),
    .w_addr  (w_addr),
    .w_data  (w_data)
  );

  // Clock generation.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Memory model: combinational 6-byte read, 4-byte write on the rising edge.
  assign ra = r_addr[7:0];
  assign r_data = {mem[8'(ra + 8'd5)], mem[8'(ra + 8'd4)], mem[8'(ra + 8'd3)],
                   mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};

  // Memory model write / clear.
  always @(posedge sys_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[w_addr[7:0]]               <= w_data[7:0];
      mem[8'(w_addr[7:0] + 8'd1)]    <= w_data[15:8];
      mem[8'(w_addr[7:0] + 8'd2)]    <= w_data[23:16];
      mem[8'(w_addr[7:0] + 8'd3)]    <= w_data[31:24];
    end
  end

  // Ack pulse counters, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (h_ack) n_h_ack <= n_h_ack + 1;
    if (m_ack) n_m_ack <= n_m_ack + 1;
    if (h_ack && m_ack) n_dual <= n_dual + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction from one requester; returns ack latency (99 on timeout),
  // the error flag, how many cycles we was high and the last write seen.
  task automatic txn(input bit is_m, input bit wr, input logic [15:0] addr,
                     input logic [31:0] wd, output int lat, output bit err,
                     output int we_cnt, output logic [15:0] wa, output logic [32:0] wdo);
    if (is_m) begin
      m_we = wr; m_addr = addr; m_wdata = wd; m_req = 1'b1;
    end else begin
      h_we = wr; h_addr = addr; h_wdata = wd; h_req = 1'b1;
    end
    lat = 99; err = 1'b0; we_cnt = 0; wa = 16'h0; wdo = 33'h0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge sys_clk); #1;
      if (we) begin
        we_cnt++; wa = w_addr; wdo = w_data;
      end
      if (is_m ? m_ack : h_ack) begin
        lat = i;
        err = is_m ? m_err : h_err;
        break;
      end
    end
    if (is_m) m_req = 1'b0; else h_req = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int lat, we_cnt, acks, got, m_ack_base, h_ack_base;
    bit err;
    logic [15:0] wa;
    logic [32:0] wdo;
    logic [3:0] seq;

    sys_rst = 1'b1; mem_clr = 1'b1;
    h_req = 1'b0; h_we = 1'b0; h_addr = 16'h0; h_wdata = 32'h0; h_excl = 1'b0;
    m_req = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 32'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_h_ack", h_ack, 1'b0);
    check("rst_m_ack", m_ack, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_r_addr", r_addr, 16'h0);
    check("rst_w_data", w_data, 33'h0);
    check("rst_h_rdata", h_rdata, 48'h0);
    sys_rst = 1'b0; mem_clr = 1'b0;
    @(posedge sys_clk); #1;

    // Host write 0x10
    txn(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, lat, err, we_cnt, wa, wdo);
    check("hw_lat", lat, 2);
    check("hw_err", err, 1'b0);
    check("hw_we_cycles", we_cnt, 1);
    check("hw_w_addr", wa, 16'h0010);
    check("hw_w_data", wdo, 33'h0_DEADBEEF);

    // Host read 0x10
    txn(1'b0, 1'b0, 16'h0010, 32'h0, lat, err, we_cnt, wa, wdo);
    check("hr_lat", lat, 2);
    check("hr_rdata", h_rdata, 48'h0000_DEADBEEF);
    check("hr_m_rdata_kept", m_rdata, 48'h0);
    check("hr_no_we", we_cnt, 0);

    // MPU range boundaries
    txn(1'b1, 1'b0, 16'd124, 32'h0, lat, err, we_cnt, wa, wdo);
    check("mr124_err", err, 1'b1);
    check("mr124_lat", lat, 2);
    check("mr124_rdata_kept", m_rdata, 48'h0);
    txn(1'b1, 1'b1, 16'd125, 32'h11223344, lat, err, we_cnt, wa, wdo);
    check("mw125_err", err, 1'b0);
    check("mw125_we_cycles", we_cnt, 1);
    check("mw125_w_addr", wa, 16'd125);
    txn(1'b1, 1'b1, 16'd126, 32'h55667788, lat, err, we_cnt, wa, wdo);
    check("mw126_err", err, 1'b1);
    check("mw126_no_we", we_cnt, 0);
    txn(1'b1, 1'b0, 16'hFFFF, 32'h0, lat, err, we_cnt, wa, wdo);
    check("mrFFFF_err", err, 1'b1);

    // Both requesting continuously: last grant was MPU, so host goes first
    h_we = 1'b0; h_addr = 16'h0000; m_we = 1'b0; m_addr = 16'h0010;
    h_req = 1'b1; m_req = 1'b1;
    seq = 4'h0; acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge sys_clk); #1;
      if (h_ack) begin seq = {seq[2:0], 1'b0}; acks++; end
      if (m_ack) begin seq = {seq[2:0], 1'b1}; acks++; end
    end
    h_req = 1'b0; m_req = 1'b0;
    @(posedge sys_clk); #1;
    check("rr_ack_count", acks, 4);
    check("rr_order", seq, 4'b0101);
    check("rr_h_rdata", h_rdata, 48'h0);
    check("rr_m_rdata", m_rdata, 48'h0000_DEADBEEF);

    // Host exclusive: MPU waits while host works
    m_ack_base = n_m_ack;
    h_excl = 1'b1; m_we = 1'b0; m_addr = 16'd123; m_req = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    txn(1'b0, 1'b1, 16'h0020, 32'hCAFEF00D, lat, err, we_cnt, wa, wdo);
    check("ex_hw_lat", lat, 2);
    txn(1'b0, 1'b0, 16'h001E, 32'h0, lat, err, we_cnt, wa, wdo);
    check("ex_hr_lat", lat, 2);
    check("ex_hr_rdata", h_rdata, 48'hCAFEF00D_0000);
    check("ex_no_m_ack", n_m_ack, m_ack_base);
    h_excl = 1'b0;
    got = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge sys_clk); #1;
      if (m_ack) begin got = i; break; end
    end
    check("ex_release_lat", got, 2);
    check("ex_m_err", m_err, 1'b0);
    check("ex_m_rdata", m_rdata, 48'h11223344_0000);
    m_req = 1'b0;
    @(posedge sys_clk); #1;

    // Reset during ACCESS of a write
    h_ack_base = n_h_ack;
    h_we = 1'b1; h_addr = 16'h0030; h_wdata = 32'h55AA55AA; h_req = 1'b1;
    @(posedge sys_clk); #1;
    check("mr_we_in_access", we, 1'b1);
    sys_rst = 1'b1; h_req = 1'b0;
    @(posedge sys_clk); #1;
    check("mr_we", we, 1'b0);
    check("mr_h_ack", h_ack, 1'b0);
    check("mr_w_addr", w_addr, 16'h0);
    check("mr_w_data", w_data, 33'h0);
    check("mr_r_addr", r_addr, 16'h0);
    check("mr_h_rdata", h_rdata, 48'h0);
    check("mr_m_rdata", m_rdata, 48'h0);
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("mr_no_late_ack", n_h_ack, h_ack_base);
    check("mr_idle_we", we, 1'b0);
    check("never_dual_ack", n_dual, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mpu_mem_arbiter.md
Name: mpu_mem_arbiter

Overview:
- Shares the single MPU program/data memory (48-bit combinational read port, 32-bit byte-addressed write port) between two requesters: the host loader (CSR/bus side) and the MPU core (fetch/store side).
- Round-robin arbitration, registered request capture and registered read data.
- Address range checking with an error acknowledge.
- Host exclusive mode, so the host can reload programs while the MPU is stalled.

Parameters:
- ADDR_MAX, 16'd128: highest valid byte address in memory.
- RD_BYTES, 6: bytes returned per read (48-bit window).
- WR_BYTES, 4: bytes written per write.

Ports:
- sys_clk input 1: system clock; all logic on rising edge.
- sys_rst input 1: synchronous, active-high reset.
- h_req input 1: host request; held until h_ack.
- h_we input 1: host write (1) / read (0).
- h_addr input 16: host byte address.
- h_wdata input 32: host write data, little-endian bytes.
- h_excl input 1: host exclusive mode; MPU is never granted while high.
- h_ack output 1: one-cycle host completion pulse.
- h_err output 1: valid with h_ack; address out of range, access suppressed.
- h_rdata output 48: host read data, valid with h_ack, held until next host ack.
- m_req input 1: MPU request.
- m_we input 1: MPU write / read.
- m_addr input 16: MPU byte address.
- m_wdata input 32: MPU write data.
- m_ack output 1: MPU completion pulse.
- m_err output 1: MPU range error, valid with m_ack.
- m_rdata output 48: MPU read data; same rules as h_rdata.
- r_addr output 16: memory read address.
- r_data input 48: memory read data, combinational from r_addr.
- we output 1: memory write enable.
- w_addr output 16: memory write address.
- w_data output 33: memory write data; bit 32 always 0.

Behaviour:
- Reset values:
  - State IDLE.
  - h_ack, m_ack, h_err, m_err, we = 0.
  - r_addr, w_addr, w_data, h_rdata, m_rdata = 0.
  - last_grant = MPU, so the host wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Candidates: host if h_req; MPU if m_req and !h_excl.
  - No candidate: stay in IDLE.
  - One candidate: grant it.
  - Both: grant the one not equal to last_grant.
  - On grant: capture we/addr/wdata into registers, set last_grant, go to ACCESS.
- ACCESS (one cycle):
  - Range check on the captured address:
    - read is legal iff addr + RD_BYTES - 1 <= ADDR_MAX;
    - write is legal iff addr + WR_BYTES - 1 <= ADDR_MAX;
    - computed at 17 bits, so 16'hFFFF + 5 is illegal and does not wrap.
  - Legal read: r_addr = captured addr; latch r_data into the granted requester's rdata register at the end of the cycle.
  - Legal write: we = 1 for exactly this cycle; w_addr = addr; w_data = {1'b0, wdata}.
  - Illegal access: we stays 0; rdata is unchanged; set the error flag.
  - Go to DONE.
- DONE:
  - Pulse the granted requester's ack for one cycle; err = range-error flag.
  - Return to IDLE.
- Latency:
  - req sampled in IDLE at cycle N; memory access at N+1; ack at N+2.
  - Minimum 3 cycles per transaction; back-to-back grants every 3 cycles.
- Handshake:
  - Requester holds req and all fields stable until ack.
  - In the cycle after ack, the requester drops req or presents a new request; it is sampled in IDLE.
  - The arbiter ignores field changes after capture.
- Simultaneous events:
  - The non-granted requester waits; no starvation. With both requesting continuously, grants alternate H, M, H, M.
- h_excl:
  - Asserted while an MPU access is in ACCESS/DONE: the MPU access completes normally.
  - Takes effect at the next IDLE.
  - Deassertion re-enables the MPU the next IDLE cycle.
- Reset mid-operation: immediate return to IDLE, no ack, we = 0 on the next cycle, pending capture discarded.
- The block never writes memory outside the ACCESS state; only one of h_ack/m_ack is ever high.

Test Plan:
- Reset, then host write h_addr=0x10, h_wdata=0xDEADBEEF → we=1 one cycle, w_addr=0x10, w_data=0x0DEADBEEF; h_ack 2 cycles after sample, h_err=0.
- Host read h_addr=0x10 after the write → h_rdata[31:0]=0xDEADBEEF with h_ack; m_rdata unchanged.
- h_req and m_req both held high for 12 cycles → grant order H, M, H, M; 4 acks total, no double ack.
- MPU read m_addr=124 (124+5 > 128) → m_ack with m_err=1, we never asserted, m_rdata unchanged. Write at 125 (125+3=128) → legal. Write at 126 → err.
- h_excl=1 with m_req high → MPU never acked while host transactions complete. Drop h_excl → m_ack within 3 cycles.
- sys_rst asserted during ACCESS of a write → no ack, we low the cycle after reset, all outputs at reset values.
